div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 180 ++++++++++++++++++
 tb/tb_div_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 64-bit RISC-V divider (DIV/DIVU/REM/REMU and -W variants).
// Restoring radix-2 divide on operand magnitudes, one quotient bit per cycle.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  funct3,
    input  logic        width_32,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [63:0] result_reg;
    logic [63:0] rem_reg;
    logic [63:0] quo_reg;
    logic [63:0] div_reg;
    logic [5:0]  iter_reg;
    logic        w32_reg;
    logic        rem_op_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;

    logic        is_signed;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic [63:0] min_neg;
    logic        div_zero;
    logic        overflow;
    logic        is_special;
    logic        accept;
    logic [63:0] fmt_a;
    logic [63:0] special_result;

    logic [64:0] rem_shift;
    logic        ge;
    logic [63:0] rem_next;
    logic [63:0] quo_next;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] sel_result;
    logic [63:0] busy_result;
    logic [5:0]  last_iter;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

    // Operand preparation from the live request inputs.
    always_comb begin
        is_signed = ~funct3[0];
        if (width_32) begin
            op_a = is_signed ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            op_b = is_signed ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            op_a = a;
            op_b = b;
        end
        neg_a      = is_signed & op_a[63];
        neg_b      = is_signed & op_b[63];
        mag_a      = neg_a ? (64'd0 - op_a) : op_a;
        mag_b      = neg_b ? (64'd0 - op_b) : op_b;
        min_neg    = width_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero   = (op_b == 64'd0);
        overflow   = is_signed && (op_a == min_neg) && (op_b == 64'hFFFF_FFFF_FFFF_FFFF);
        is_special = ~funct3[2] | div_zero | overflow;
        accept     = in_valid && in_ready_reg && !flush;
        fmt_a      = width_32 ? {{32{a[31]}}, a[31:0]} : a;

        special_result = 64'd0;
        if (funct3[2]) begin
            if (div_zero)
                special_result = funct3[1] ? fmt_a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (overflow)
                special_result = funct3[1] ? 64'd0 : op_a;
        end
    end

    // One restoring step; the final step also produces the signed, formatted result.
    always_comb begin
        rem_shift   = {rem_reg, quo_reg[63]};
        ge          = (rem_shift >= {1'b0, div_reg});
        rem_next    = ge ? 64'(rem_shift - {1'b0, div_reg}) : rem_shift[63:0];
        quo_next    = {quo_reg[62:0], ge};
        q_fix       = neg_q_reg ? (64'd0 - quo_next) : quo_next;
        r_fix       = neg_r_reg ? (64'd0 - rem_next) : rem_next;
        sel_result  = rem_op_reg ? r_fix : q_fix;
        busy_result = w32_reg ? {{32{sel_result[31]}}, sel_result[31:0]} : sel_result;
        last_iter   = w32_reg ? 6'd31 : 6'd63;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= 64'd0;
            rem_reg       <= 64'd0;
            quo_reg       <= 64'd0;
            div_reg       <= 64'd0;
            iter_reg      <= 6'd0;
            w32_reg       <= 1'b0;
            rem_op_reg    <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (is_special) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= special_result;
                        end else begin
                            state_reg  <= BUSY;
                            rem_reg    <= 64'd0;
                            // -W dividends are parked in the upper half so 32 steps consume them.
                            quo_reg    <= width_32 ? {mag_a[31:0], 32'd0} : mag_a;
                            div_reg    <= mag_b;
                            iter_reg   <= 6'd0;
                            w32_reg    <= width_32;
                            rem_op_reg <= funct3[1];
                            neg_q_reg  <= neg_a ^ neg_b;
                            neg_r_reg  <= neg_a;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        rem_reg  <= rem_next;
                        quo_reg  <= quo_next;
                        iter_reg <= iter_reg + 6'd1;
                        if (iter_reg == last_iter) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= busy_result;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && accept && !funct3[2])
            $error("div_unit: non-divide funct3 %b accepted", funct3);
    end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: result values, latency, handshake, flush and reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic [2:0]  funct3 = 3'b100;
    logic        width_32 = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .funct3   (funct3),
        .width_32 (width_32),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f, input logic w, input logic [63:0] aa, input logic [63:0] bb);
        @(negedge clk);
        funct3 = f; width_32 = w; a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // k counts edges after the accepting edge; sampling on the negedge before edge k.
    task automatic wait_result(output int lat, output logic [63:0] res);
        lat = -1;
        res = 64'd0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] aa, input logic [63:0] bb,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        logic [63:0] res;
        start_op(f, w, aa, bb);
        wait_result(lat, res);
        $display("op %-10s f3=%b w32=%b a=%h b=%h -> %h at edge +%0d", tag, f, w, aa, bb, res, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, res, exp_res);
        consume();
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] res;

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", result, 64'd0);

        run_op("div_m7_2",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div_7_m2",  3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_7_m2",  3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
        run_op("divu_big",  3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65);
        run_op("divu_z",    3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_z",    3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("div_ovf",   3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",   3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divuw",     3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        run_op("remw",      3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divw",      3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("divw_ovf",  3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);

        // Back-pressure: result must hold while out_ready is low.
        start_op(3'b101, 1'b0, 64'd100, 64'd7);
        wait_result(lat, res);
        $display("op %-10s f3=101 w32=0 a=100 b=7 -> %h at edge +%0d", "hold", res, lat);
        check_eq("hold_lat", 64'(lat), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_result", result, 64'd14);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        // A request offered on the draining edge must not be taken.
        funct3 = 3'b101; width_32 = 1'b0; a = 64'd5; b = 64'd1; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        check_eq("drain_in_ready", 64'(in_ready), 64'd1);
        check_eq("drain_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("drain_no_accept", 64'(in_ready), 64'd1);

        // flush while idle blocks acceptance
        @(negedge clk);
        funct3 = 3'b101; a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check_eq("idle_flush_in_ready", 64'(in_ready), 64'd1);

        // flush in DONE wins over out_ready
        start_op(3'b101, 1'b0, 64'h1234, 64'd0);
        wait_result(lat, res);
        check_eq("done_flush_pre", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        check_eq("done_flush_valid", 64'(out_valid), 64'd0);
        check_eq("done_flush_in_ready", 64'(in_ready), 64'd1);

        // flush at BUSY cycle 20
        start_op(3'b101, 1'b0, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check_eq("busy_pre_flush", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_eq("busy_flush_in_ready", 64'(in_ready), 64'd1);
        check_eq("busy_flush_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("busy_flush_no_result", 64'(seen), 64'd0);

        // asynchronous reset at BUSY cycle 30
        start_op(3'b101, 1'b0, 64'd100, 64'd7);
        repeat (29) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("async_rst_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_result", result, 64'd0);
        #3 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("rst_no_result", 64'(seen), 64'd0);
        run_op("divu_after", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_after", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
